uart_rx_fifo: RTL and testbench

Receive FIFO of the UART, between the RX shift/deserialiser and the register file and interrupt generator. Stores up to DEPTH received characters, each with its parity-error, framing-error and break flags. Produces the data-ready, head-entry error and below-trigger-level indications. The interrupt generator consumes those indications, and RBR reads drain the FIFO.

---
 rtl/uart_rx_fifo_pkg.sv | 37 +++
 rtl/uart_fifo_mem.sv | 26 ++
 rtl/uart_rx_fifo.sv | 137 +++++++++++++
 tb/tb_uart_rx_fifo.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_fifo_pkg.sv
// Shared UART FIFO definitions: FCR trigger encodings with their decoded levels,
// entry flag positions above the character bits, and small helpers.
package uart_rx_fifo_pkg;

    localparam logic [1:0] TRIG_1  = 2'b00;
    localparam logic [1:0] TRIG_4  = 2'b01;
    localparam logic [1:0] TRIG_8  = 2'b10;
    localparam logic [1:0] TRIG_14 = 2'b11;

    localparam int TRIG_1_LVL  = 32'sd1;
    localparam int TRIG_4_LVL  = 32'sd4;
    localparam int TRIG_8_LVL  = 32'sd8;
    localparam int TRIG_14_LVL = 32'sd14;

    // Flag offsets above the DATA_W character bits of a stored entry
    localparam int ENT_PE = 32'sd0;
    localparam int ENT_FE = 32'sd1;
    localparam int ENT_BI = 32'sd2;

    // Levels scale with depth; the named levels above are the DEPTH=16 values
    function automatic int trig_decode(input logic [1:0] code, input int depth);
        int lvl;
        case (code)
            TRIG_1:  lvl = TRIG_1_LVL;
            TRIG_4:  lvl = depth / 32'sd4;
            TRIG_8:  lvl = depth / 32'sd2;
            TRIG_14: lvl = depth - 32'sd2;
            default: lvl = TRIG_1_LVL;
        endcase
        return lvl;
    endfunction

    function automatic logic any_flag(input logic [2:0] flags);
        return |flags;
    endfunction

endpackage

// File: rtl/uart_fifo_mem.sv
// Register-array FIFO storage: one synchronous write port, one asynchronous read port.
// Contents are not reset; the owning FIFO masks its outputs while empty.
module uart_fifo_mem #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 11
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem_r [DEPTH];

    // Write port
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive FIFO: stores characters with pe/fe/bi flags, tracks occupancy and
// erroneous entries, and presents the head entry show-ahead.
module uart_rx_fifo
    import uart_rx_fifo_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [DATA_W-1:0]        push_data,
    input  logic                     push_pe,
    input  logic                     push_fe,
    input  logic                     push_bi,
    input  logic                     pop,
    input  logic                     fifo_clr,
    input  logic [1:0]               trig_lvl,
    output logic [DATA_W-1:0]        rd_data,
    output logic                     dr,
    output logic                     below_level,
    output logic                     pe,
    output logic                     fe,
    output logic                     bi,
    output logic                     fifo_err,
    output logic                     overrun,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = DATA_W + 3;

    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic [CW-1:0] err_cnt_r;
    logic          overrun_r;

    logic          full_s;
    logic          head_vld_s;
    logic          push_ok_s;
    logic          pop_ok_s;
    logic          drop_s;
    logic          err_inc_s;
    logic          err_dec_s;
    logic [CW-1:0] count_nxt_s;
    logic [CW-1:0] err_cnt_nxt_s;
    logic [EW-1:0] wr_entry_s;
    logic [EW-1:0] rd_entry_s;
    logic [2:0]    head_flags_s;
    logic          below_s;

    assign full_s       = (count_r == CW'(DEPTH));
    assign head_vld_s   = (count_r != {CW{1'b0}});
    assign wr_entry_s   = {push_bi, push_fe, push_pe, push_data};
    assign head_flags_s = {rd_entry_s[DATA_W+ENT_BI], rd_entry_s[DATA_W+ENT_FE],
                           rd_entry_s[DATA_W+ENT_PE]};

    // Accept/drop decisions and next occupancy; a pop frees room for a push when full
    always_comb begin
        push_ok_s     = push && (!full_s || pop);
        pop_ok_s      = pop && head_vld_s;
        drop_s        = push && full_s && !pop;
        err_inc_s     = push_ok_s && any_flag({push_bi, push_fe, push_pe});
        err_dec_s     = pop_ok_s && any_flag(head_flags_s);
        count_nxt_s   = count_r;
        err_cnt_nxt_s = err_cnt_r;
        case ({push_ok_s, pop_ok_s})
            2'b10:   count_nxt_s = count_r + {{(CW-1){1'b0}}, 1'b1};
            2'b01:   count_nxt_s = count_r - {{(CW-1){1'b0}}, 1'b1};
            default: count_nxt_s = count_r;
        endcase
        case ({err_inc_s, err_dec_s})
            2'b10:   err_cnt_nxt_s = err_cnt_r + {{(CW-1){1'b0}}, 1'b1};
            2'b01:   err_cnt_nxt_s = err_cnt_r - {{(CW-1){1'b0}}, 1'b1};
            default: err_cnt_nxt_s = err_cnt_r;
        endcase
    end

    // Pointer, occupancy, error-count and overrun state; FCR clear discards same-cycle events
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r  <= {AW{1'b0}};
            rd_ptr_r  <= {AW{1'b0}};
            count_r   <= {CW{1'b0}};
            err_cnt_r <= {CW{1'b0}};
            overrun_r <= 1'b0;
        end else if (fifo_clr) begin
            wr_ptr_r  <= {AW{1'b0}};
            rd_ptr_r  <= {AW{1'b0}};
            count_r   <= {CW{1'b0}};
            err_cnt_r <= {CW{1'b0}};
            overrun_r <= 1'b0;
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + {{(AW-1){1'b0}}, 1'b1};
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + {{(AW-1){1'b0}}, 1'b1};
            end
            count_r   <= count_nxt_s;
            err_cnt_r <= err_cnt_nxt_s;
            overrun_r <= drop_s;
        end
    end

    uart_fifo_mem #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) u_mem (
        .clk   (clk),
        .we    (push_ok_s && !fifo_clr),
        .waddr (wr_ptr_r),
        .wdata (wr_entry_s),
        .raddr (rd_ptr_r),
        .rdata (rd_entry_s)
    );

    // Trigger comparison follows trig_lvl combinationally
    always_comb begin
        below_s = (int'(count_r) < trig_decode(trig_lvl, DEPTH));
    end

    assign rd_data     = head_vld_s ? rd_entry_s[DATA_W-1:0] : {DATA_W{1'b0}};
    assign pe          = head_vld_s & head_flags_s[0];
    assign fe          = head_vld_s & head_flags_s[1];
    assign bi          = head_vld_s & head_flags_s[2];
    assign dr          = head_vld_s;
    assign below_level = below_s;
    assign fifo_err    = (err_cnt_r != {CW{1'b0}});
    assign overrun     = overrun_r;
    assign count       = count_r;
    assign full        = full_s;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: hand-computed expectations checked with
// immediate assertions after each stimulus step.
module tb_uart_rx_fifo;

    logic       clk;
    logic       rst_n;
    logic       push;
    logic [7:0] push_data;
    logic       push_pe;
    logic       push_fe;
    logic       push_bi;
    logic       pop;
    logic       fifo_clr;
    logic [1:0] trig_lvl;
    logic [7:0] rd_data;
    logic       dr;
    logic       below_level;
    logic       pe;
    logic       fe;
    logic       bi;
    logic       fifo_err;
    logic       overrun;
    logic [4:0] count;
    logic       full;

    int total = 0;
    int bad   = 0;

    uart_rx_fifo #(.DEPTH(16), .DATA_W(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .push        (push),
        .push_data   (push_data),
        .push_pe     (push_pe),
        .push_fe     (push_fe),
        .push_bi     (push_bi),
        .pop         (pop),
        .fifo_clr    (fifo_clr),
        .trig_lvl    (trig_lvl),
        .rd_data     (rd_data),
        .dr          (dr),
        .below_level (below_level),
        .pe          (pe),
        .fe          (fe),
        .bi          (bi),
        .fifo_err    (fifo_err),
        .overrun     (overrun),
        .count       (count),
        .full        (full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock edge, then settle 1 time unit so outputs are sampled away from the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_push(input logic [7:0] d, input logic p, input logic f, input logic b);
        push = 1'b1; push_data = d; push_pe = p; push_fe = f; push_bi = b;
        tick();
        push = 1'b0; push_data = 8'h00; push_pe = 1'b0; push_fe = 1'b0; push_bi = 1'b0;
    endtask

    task automatic do_pop();
        pop = 1'b1;
        tick();
        pop = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; push = 1'b0; push_data = 8'h00; push_pe = 1'b0; push_fe = 1'b0;
        push_bi = 1'b0; pop = 1'b0; fifo_clr = 1'b0; trig_lvl = 2'b00;
        #2;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_dr", 32'(dr), 32'd0);
        chk("rst_below", 32'(below_level), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_rd_data", 32'(rd_data), 32'd0);
        chk("rst_flags", 32'({pe, fe, bi, fifo_err, overrun}), 32'd0);
        #10;
        rst_n = 1'b1;
        tick();

        // First character
        do_push(8'h41, 1'b0, 1'b0, 1'b0);
        chk("p1_dr", 32'(dr), 32'd1);
        chk("p1_count", 32'(count), 32'd1);
        chk("p1_rd_data", 32'(rd_data), 32'h41);
        chk("p1_flags", 32'({pe, fe, bi}), 32'd0);
        chk("p1_below", 32'(below_level), 32'd0);
        do_pop();
        chk("p1_pop_count", 32'(count), 32'd0);
        chk("p1_pop_rd_data", 32'(rd_data), 32'd0);

        // Trigger level 8
        trig_lvl = 2'b10;
        for (int i = 0; i < 7; i++) do_push(8'(i), 1'b0, 1'b0, 1'b0);
        chk("t8_count7", 32'(count), 32'd7);
        chk("t8_below7", 32'(below_level), 32'd1);
        do_push(8'h07, 1'b0, 1'b0, 1'b0);
        chk("t8_below8", 32'(below_level), 32'd0);
        trig_lvl = 2'b11;
        #1;
        chk("t14_below8_comb", 32'(below_level), 32'd1);
        trig_lvl = 2'b10;
        #1;
        do_pop();
        chk("t8_pop_below", 32'(below_level), 32'd1);
        fifo_clr = 1'b1;
        tick();
        fifo_clr = 1'b0;
        chk("clr_count", 32'(count), 32'd0);

        // Fill, overrun, drain in order
        for (int i = 0; i < 16; i++) do_push(8'(i), 1'b0, 1'b0, 1'b0);
        chk("fill_full", 32'(full), 32'd1);
        chk("fill_count", 32'(count), 32'd16);
        chk("fill_below_t8", 32'(below_level), 32'd0);
        do_push(8'hAA, 1'b0, 1'b0, 1'b0);
        chk("ovr_pulse", 32'(overrun), 32'd1);
        chk("ovr_count", 32'(count), 32'd16);
        tick();
        chk("ovr_clear", 32'(overrun), 32'd0);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("drain_%0d", i), 32'(rd_data), 32'(i));
            do_pop();
        end
        chk("drain_dr", 32'(dr), 32'd0);
        chk("drain_rd_data", 32'(rd_data), 32'd0);
        do_pop();
        chk("pop_empty_count", 32'(count), 32'd0);

        // Error flags at the head and the error counter
        do_push(8'h10, 1'b0, 1'b1, 1'b0);
        do_push(8'h11, 1'b0, 1'b0, 1'b0);
        chk("err_fe", 32'(fe), 32'd1);
        chk("err_pe_bi", 32'({pe, bi}), 32'd0);
        chk("err_fifo_err", 32'(fifo_err), 32'd1);
        chk("err_rd_data", 32'(rd_data), 32'h10);
        do_pop();
        chk("err_pop_fe", 32'(fe), 32'd0);
        chk("err_pop_fifo_err", 32'(fifo_err), 32'd0);
        chk("err_pop_rd_data", 32'(rd_data), 32'h11);
        do_pop();

        // Push and pop together while empty: only the push lands
        push = 1'b1; push_data = 8'h66; pop = 1'b1;
        tick();
        push = 1'b0; pop = 1'b0;
        chk("pp_empty_count", 32'(count), 32'd1);
        chk("pp_empty_rd_data", 32'(rd_data), 32'h66);
        do_pop();

        // Push and pop together while full, with pointer wrap
        for (int i = 0; i < 16; i++) do_push(8'(8'h20 + i), 1'b0, 1'b0, 1'b0);
        chk("ppf_head", 32'(rd_data), 32'h20);
        push = 1'b1; push_data = 8'h55; pop = 1'b1;
        tick();
        push = 1'b0; push_data = 8'h00; pop = 1'b0;
        chk("ppf_count", 32'(count), 32'd16);
        chk("ppf_overrun", 32'(overrun), 32'd0);
        chk("ppf_new_head", 32'(rd_data), 32'h21);
        for (int i = 1; i < 16; i++) do_pop();
        chk("ppf_last", 32'(rd_data), 32'h55);
        chk("ppf_last_count", 32'(count), 32'd1);
        do_pop();

        // Clear wins over a same-cycle push
        for (int i = 0; i < 5; i++) do_push(8'(8'h30 + i), 1'b0, 1'b0, 1'b0);
        chk("clr5_count", 32'(count), 32'd5);
        fifo_clr = 1'b1; push = 1'b1; push_data = 8'h77;
        tick();
        fifo_clr = 1'b0; push = 1'b0; push_data = 8'h00;
        chk("clrp_count", 32'(count), 32'd0);
        chk("clrp_dr", 32'(dr), 32'd0);
        chk("clrp_overrun", 32'(overrun), 32'd0);

        // Asynchronous reset mid-stream
        do_push(8'h81, 1'b1, 1'b0, 1'b1);
        do_push(8'h82, 1'b0, 1'b0, 1'b0);
        chk("ar_pre_pe_bi", 32'({pe, bi}), 32'd3);
        chk("ar_pre_fifo_err", 32'(fifo_err), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("ar_count", 32'(count), 32'd0);
        chk("ar_dr", 32'(dr), 32'd0);
        chk("ar_below", 32'(below_level), 32'd1);
        chk("ar_rd_data", 32'(rd_data), 32'd0);
        chk("ar_flags", 32'({pe, fe, bi, fifo_err, overrun, full}), 32'd0);
        #10;
        rst_n = 1'b1;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
